// File: rtl/fetch_queue.sv
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Circular instruction queue between fetch and decode, with
//             branch-redirect flush.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [31:0]                in_pc,
   input  logic [31:0]                in_instr,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [31:0]                out_pc,
   output logic [31:0]                out_instr,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] c_FULL    = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] c_EMPTY   = '0;
   localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
   localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);

   logic [63:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic w_enq;
   logic w_deq;
   logic [63:0] w_head;

   // Reset also gates in_ready so the PC stage stalls while the queue is held.
   assign in_ready  = !reset && !flush && (count_q != c_FULL);
   assign out_valid = !flush && (count_q != c_EMPTY);

   assign w_enq = in_valid  && in_ready;
   assign w_deq = out_valid && out_ready;

   assign w_head    = mem_q[rd_ptr_q];
   assign out_pc    = w_head[63:32];
   assign out_instr = w_head[31:0];
   assign count     = count_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (w_enq) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
         end
         if (w_deq) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
         end
         case ({w_enq, w_deq})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Flush leaves stored entries intact; only reset clears them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (w_enq) begin
         mem_q[wr_ptr_q] <= {in_pc, in_instr};
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
`default_nettype none

module tb_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_instr = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_ready = 1'b0;
   logic [2:0]  count;

   int total = 0;
   int bad   = 0;

   logic [63:0] mq[$];

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .out_ready (out_ready),
      .count     (count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return pc ^ 32'hA5C3_0F00;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain FIFO of {pc, instr}.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
      end else if (flush) begin
         mq.delete();
      end else begin
         logic [63:0] head;
         bit do_enq, do_deq;
         do_enq = in_valid && (mq.size() < DEPTH);
         do_deq = out_ready && (mq.size() > 0);
         if (do_deq) head = mq.pop_front();
         if (do_enq) mq.push_back({in_pc, in_instr});
      end
   end

   always @(negedge clk) begin
      logic exp_ir, exp_ov;
      exp_ir = !reset && !flush && (mq.size() < DEPTH);
      exp_ov = !flush && (mq.size() > 0);
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_in_ready", 32'(in_ready), 32'(exp_ir));
      chk("m_out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov && out_valid) begin
         chk("m_out_pc", out_pc, mq[0][63:32]);
         chk("m_out_instr", out_instr, mq[0][31:0]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [31:0] pc);
      in_valid = v;
      in_pc    = pc;
      in_instr = instr_of(pc);
   endtask

   initial begin
      // Reset state
      step();
      step();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Fill then drain
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 32'(i * 4));
         step();
      end
      chk("fill_count", 32'(count), 32'd4);
      chk("fill_in_ready", 32'(in_ready), 32'd0);
      set_in(1'b1, 32'h10);
      step();
      chk("fifth_push_count", 32'(count), 32'd4);
      set_in(1'b0, 32'h0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_pc", out_pc, 32'(i * 4));
         chk("drain_instr", out_instr, instr_of(32'(i * 4)));
         step();
      end
      chk("drain_empty_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      // Streaming at occupancy 1 across many pointer wraps
      set_in(1'b1, 32'h100);
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         chk("stream_head", out_pc, 32'h100 + 32'(i * 4));
         set_in(1'b1, 32'h104 + 32'(i * 4));
         step();
      end
      chk("stream_count", 32'(count), 32'd1);
      set_in(1'b0, 32'h0);
      step();
      out_ready = 1'b0;
      chk("stream_drained", 32'(count), 32'd0);

      // Flush with a concurrent push
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 32'h200 + 32'(i * 4));
         step();
      end
      chk("pre_flush_count", 32'(count), 32'd3);
      flush = 1'b1;
      set_in(1'b1, 32'h40);
      #1;
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      step();
      flush = 1'b0;
      set_in(1'b0, 32'h0);
      #1;
      chk("post_flush_count", 32'(count), 32'd0);
      set_in(1'b1, 32'h80);
      step();
      set_in(1'b0, 32'h0);
      chk("after_flush_head", out_pc, 32'h80);
      chk("after_flush_count", 32'(count), 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Full with a dequeue: input must not be written
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 32'h300 + 32'(i * 4));
         step();
      end
      chk("full_count", 32'(count), 32'd4);
      set_in(1'b1, 32'h500);
      out_ready = 1'b1;
      #1;
      chk("full_in_ready", 32'(in_ready), 32'd0);
      step();
      set_in(1'b0, 32'h0);
      chk("full_deq_count", 32'(count), 32'd3);
      chk("full_deq_head", out_pc, 32'h304);
      for (int i = 0; i < 3; i++) step();
      chk("full_drained", 32'(count), 32'd0);
      out_ready = 1'b0;

      // Asynchronous reset between edges
      for (int i = 0; i < 2; i++) begin
         set_in(1'b1, 32'h600 + 32'(i * 4));
         step();
      end
      set_in(1'b0, 32'h0);
      chk("pre_arst_count", 32'(count), 32'd2);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_pc", out_pc, 32'd0);
      step();
      reset = 1'b0;
      #1;
      chk("arst_release_in_ready", 32'(in_ready), 32'd1);

      // Empty queue ignores out_ready
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      chk("empty_count", 32'(count), 32'd0);
      chk("empty_out_valid", 32'(out_valid), 32'd0);
      set_in(1'b1, 32'h700);
      step();
      set_in(1'b0, 32'h0);
      chk("empty_then_push_head", out_pc, 32'h700);
      step();
      chk("empty_final_count", 32'(count), 32'd0);
      out_ready = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
